// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: WIDTH-bit unsigned adder that adds CHUNK bits per clock and carries between cycles in a register.
// Define CHUNKED_ADDER_OVERFLOW_EN to add a registered signed-overflow output.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
  logic             c_q, busy_q, done_q, cout_q;
  logic [CW-1:0]    cnt_q;

  logic [CHUNK:0]   chunk_sum_d;
  logic [WIDTH-1:0] psum_d;

  assign chunk_sum_d = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
  // New chunk enters at the MSB end; written as shifts so CHUNK == WIDTH needs no special case.
  assign psum_d = (psum_q >> CHUNK) | (WIDTH'(chunk_sum_d[CHUNK-1:0]) << (WIDTH - CHUNK));

`ifdef CHUNKED_ADDER_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;
  // Carry into the MSB recovered from the MSB's operand and sum bits, then XORed with carry out.
  assign ovf_d = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum_d[CHUNK-1] ^ chunk_sum_d[CHUNK];
  assign overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST) begin
      ovf_q <= ovf_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= carry_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> CHUNK;
          b_q    <= b_q >> CHUNK;
          c_q    <= chunk_sum_d[CHUNK];
          psum_q <= psum_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= psum_d;
            cout_q  <= chunk_sum_d[CHUNK];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: CHUNK=4 main instance plus CHUNK=1 and CHUNK=16 sweep instances.
module tb_chunked_serial_adder;
  localparam int W = 16;
  typedef struct packed { logic [W-1:0] s; logic c; logic v; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0, start1 = 1'b0, start16 = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic cin = 1'b0;
  logic busy4, done4, cout4, busy1, done1, cout1, busy16, done16, cout16;
  logic [W-1:0] sum4, sum1, sum16;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  logic ovf4, ovf1, ovf16;
`endif
  int errors = 0, checks = 0;
  int dones4 = 0;
  logic prev4 = 1'b0;
  exp_t q4[$], q1[$], q16[$];

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(W), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .carry_in(cin),
    .busy(busy4), .done(done4), .sum(sum4),
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    .overflow(ovf4),
`endif
    .carry_out(cout4));

  chunked_serial_adder #(.WIDTH(W), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .carry_in(cin),
    .busy(busy1), .done(done1), .sum(sum1),
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    .overflow(ovf1),
`endif
    .carry_out(cout1));

  chunked_serial_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a), .b(b), .carry_in(cin),
    .busy(busy16), .done(done16), .sum(sum16),
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    .overflow(ovf16),
`endif
    .carry_out(cout16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = x[W-1] ^ y[W-1] ^ t[W-1] ^ t[W];
    return e;
  endfunction

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done4) begin
      dones4++;
      chk("done4_pulse_width", {31'b0, prev4}, 32'd0);
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL done4_unexpected: got done with no pending operation");
      end else begin
        e = q4.pop_front();
        chk("sum4", {16'b0, sum4}, {16'b0, e.s});
        chk("cout4", {31'b0, cout4}, {31'b0, e.c});
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        chk("ovf4", {31'b0, ovf4}, {31'b0, e.v});
`endif
      end
    end
    prev4 = done4;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL done1_unexpected: got done with no pending operation");
      end else begin
        e = q1.pop_front();
        chk("sum1", {16'b0, sum1}, {16'b0, e.s});
        chk("cout1", {31'b0, cout1}, {31'b0, e.c});
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        chk("ovf1", {31'b0, ovf1}, {31'b0, e.v});
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done16) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL done16_unexpected: got done with no pending operation");
      end else begin
        e = q16.pop_front();
        chk("sum16", {16'b0, sum16}, {16'b0, e.s});
        chk("cout16", {31'b0, cout16}, {31'b0, e.c});
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        chk("ovf16", {31'b0, ovf16}, {31'b0, e.v});
`endif
      end
    end
  end

  task automatic run4(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input exp_t e);
    int n;
    @(negedge clk);
    a = x; b = y; cin = c; start4 = 1'b1;
    q4.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      n++;
      if (!done4) chk("busy4_during_op", {31'b0, busy4}, 32'd1);
    end while (!done4 && n < 40);
    chk("latency4", n - 1, 32'd4);
    chk("busy4_at_done", {31'b0, busy4}, 32'd0);
  endtask

  task automatic run_sweep(input int nch, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n;
    logic d;
    @(negedge clk);
    a = x; b = y; cin = c;
    if (nch == 16) begin start1 = 1'b1; q1.push_back(model(x, y, c)); end
    else begin start16 = 1'b1; q16.push_back(model(x, y, c)); end
    n = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0; start16 = 1'b0;
      n++;
      d = (nch == 16) ? done1 : done16;
    end while (!d && n < 40);
    chk((nch == 16) ? "latency_chunk1" : "latency_chunk16", n - 1, nch);
  endtask

  initial begin
    int base, n;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy4}, 32'd0);
    chk("rst_done", {31'b0, done4}, 32'd0);
    chk("rst_sum", {16'b0, sum4}, 32'd0);
    chk("rst_cout", {31'b0, cout4}, 32'd0);
    rst_n = 1'b1;

    run4(16'h1234, 16'h4321, 1'b0, '{s: 16'h5555, c: 1'b0, v: 1'b0});
    run4(16'hFFFF, 16'h0001, 1'b0, '{s: 16'h0000, c: 1'b1, v: 1'b0});
    run4(16'h7FFF, 16'h0000, 1'b1, '{s: 16'h8000, c: 1'b0, v: 1'b1});

    // Start while busy must be ignored; previous result holds until done.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start4 = 1'b1;
    q4.push_back('{s: 16'h0002, c: 1'b0, v: 1'b0});
    @(negedge clk);
    start4 = 1'b0;
    chk("hold_sum_1", {16'b0, sum4}, 32'h8000);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("hold_sum_2", {16'b0, sum4}, 32'h8000);
    chk("hold_cout", {31'b0, cout4}, 32'd0);
    base = dones4;
    n = 0;
    while (!done4 && n < 20) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    chk("ignored_start_no_extra_done", dones4 - base, 32'd1);

    // Start held high: one accepted operation every 5 cycles.
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j > 0) chk("b2b_done_timing", {31'b0, done4}, {31'b0, (j % 5 == 0)});
      a = 16'(j * 16'h1111 + 7);
      b = 16'hF00F ^ 16'(j * 16'h0321);
      cin = j[0];
      start4 = 1'b1;
      if (j % 5 == 0) q4.push_back(model(a, b, cin));
    end
    @(negedge clk);
    start4 = 1'b0;
    chk("b2b_last_done", {31'b0, done4}, 32'd1);

    // Reset during an operation aborts it without a done pulse.
    repeat (3) @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy4}, 32'd0);
    chk("midrst_done", {31'b0, done4}, 32'd0);
    chk("midrst_sum", {16'b0, sum4}, 32'd0);
    chk("midrst_cout", {31'b0, cout4}, 32'd0);
    base = dones4;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", dones4 - base, 32'd0);
    chk("midrst_idle", {31'b0, busy4}, 32'd0);

    // CHUNK=1 and CHUNK=16 against the reference model.
    run_sweep(16, 16'hFFFF, 16'hFFFF, 1'b1);
    run_sweep(16, 16'h7FFF, 16'h0001, 1'b0);
    run_sweep(1, 16'hFFFF, 16'hFFFF, 1'b1);
    run_sweep(1, 16'h7FFF, 16'h0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] x, y;
      logic c;
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      run_sweep(16, x, y, c);
      run_sweep(1, x, y, c);
    end

    repeat (3) @(negedge clk);
    chk("q4_drained", q4.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q16_drained", q16.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder that extends the single-bit full adder to WIDTH-bit operands.
- Adds CHUNK bits per clock and ripples the carry between cycles through a register.
- Trades latency for area where a full-width combinational adder is too large.
- Start/busy/done handshake to a host sequencer; the result is held stable until the next operation completes.

Parameters:
WIDTH, 16, operand and sum width in bits; must be >= 1
CHUNK, 4, bits added per cycle; must divide WIDTH exactly; NCH = WIDTH/CHUNK

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
carry_in  input  1  carry into bit 0; captured with a/b
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when sum/carry_out update
sum  output  WIDTH  registered result
carry_out  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0, and all internal operand, partial-sum and chunk-count registers are 0.
- States: IDLE and RUN.
- IDLE, start=1:
  - capture a, b and carry_in into internal shift registers;
  - chunk counter = 0;
  - next state = RUN, with busy=1 from the following cycle.
- RUN, each edge:
  - compute the (CHUNK+1)-bit sum of the low CHUNK bits of the A reg, the low CHUNK bits of the B reg, and the carry reg;
  - shift the CHUNK-bit result into the MSB end of the partial-sum reg;
  - shift the A and B regs right by CHUNK;
  - carry reg = bit CHUNK of the chunk sum;
  - counter += 1.
- RUN, edge where the counter reaches NCH-1 (final chunk):
  - sum = final partial sum, carry_out = final carry;
  - done=1 for exactly one cycle, busy=0;
  - state = IDLE.
- Latency: start accepted at edge E0 -> done high and sum valid after edge E(NCH). With CHUNK=WIDTH, done follows the start edge by exactly one edge.
- Arithmetic: unsigned modulo 2^WIDTH; carry_out is the true bit WIDTH of a+b+carry_in.
- Result hold: sum and carry_out change only on completion edges. They stay stable during a following operation and are never exposed as partial values.
- start while busy=1: ignored; no recapture, no effect on the operation in flight.
- start high in the done cycle: state is already IDLE, so it is accepted. This gives back-to-back operations with a throughput of one result per NCH+1 cycles.
- Input changes: a/b/carry_in changing after capture have no effect.
- Reset mid-operation: immediate abort; all outputs return to reset values and no done pulse is produced.
- Counter width: clog2(NCH), minimum 1 bit.

Optional Feature:
- Macro: CHUNKED_ADDER_OVERFLOW_EN.
- When defined:
  - adds output port overflow (1 bit), reset 0;
  - overflow = signed two's-complement overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - registered and updated on the same completion edge as sum.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16, CHUNK=4, a=0x1234, b=0x4321, carry_in=0, start for 1 cycle -> busy high for 4 cycles; done pulses after edge E4; sum=0x5555, carry_out=0.
- a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0. Then a=0x7FFF, b=0x0000, carry_in=1 -> sum=0x8000, carry_out=0, overflow=1 (macro defined).
- Start 0x0001+0x0001, then pulse start with 0xAAAA/0x5555 two cycles later -> second start ignored; sum=0x0002; previous sum holds until done.
- start held continuously with changing operands -> one result per 5 cycles; each sum matches the operands present at its acceptance edge.
- Assert rst_n=0 at E2 of an addition -> busy, done, sum and carry_out are 0 immediately; no done pulse after release.
- Sweep CHUNK=1 and CHUNK=16 with random operands against a reference model -> results match; latency 16 and 1 edges respectively.
